urm_trigger: RTL and testbench

URM_TRIGGER -- requirements
Module: urm_trigger

---
 rtl/urm_trigger.sv | 156 +++++++++++++++
 tb/tb_urm_trigger.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/urm_trigger.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : urm_trigger                                                   |
// | Brief    : Ultrasonic range module driver: trigger pulse, echo timing.   |
// |            Define URM_TRIGGER_AUTO_EN for free-running ranging.          |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module urm_trigger #(
   parameter int unsigned TRIG_CYCLES         = 500,
   parameter int unsigned ECHO_TIMEOUT_CYCLES = 1500000,
   parameter int unsigned HOLDOFF_CYCLES      = 3000000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        i_start,
   input  logic        i_echo,
   output logic        o_trigger,
   output logic        o_busy,
   output logic [23:0] o_echo_cycles,
   output logic        o_valid,
   output logic        o_timeout
);

`ifdef URM_TRIGGER_AUTO_EN
   localparam bit C_AUTO = 1'b1;
`else
   localparam bit C_AUTO = 1'b0;
`endif

   localparam logic [23:0] C_CNT_MAX   = 24'hFF_FFFF;
   localparam logic [23:0] C_TRIG_LAST = 24'(TRIG_CYCLES - 1);
   localparam logic [23:0] C_RISE_LAST = 24'(ECHO_TIMEOUT_CYCLES - 1);
   localparam logic [23:0] C_HOLD_LAST = 24'(HOLDOFF_CYCLES - 1);
   // The rise clock is already one high sample, so MEASURE gives up two counts early.
   localparam logic [23:0] C_MEAS_LAST = (ECHO_TIMEOUT_CYCLES >= 2) ?
                                         24'(ECHO_TIMEOUT_CYCLES - 2) : 24'd0;

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_TRIG      = 3'd1,
      S_WAIT_RISE = 3'd2,
      S_MEASURE   = 3'd3,
      S_HOLDOFF   = 3'd4
   } state_t;

   state_t      r_state;
   logic [23:0] r_cnt;
   logic        r_echo_meta;
   logic        r_echo_s;
   logic        r_echo_d;

   logic        w_rise;
   logic        w_fall;
   logic [23:0] w_cnt_inc;
   logic [23:0] w_meas_total;

   assign w_rise       = r_echo_s & ~r_echo_d;
   assign w_fall       = ~r_echo_s & r_echo_d;
   assign w_cnt_inc    = (r_cnt == C_CNT_MAX) ? r_cnt : r_cnt + 24'd1;
   assign w_meas_total = w_cnt_inc;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_echo_meta <= 1'b0;
         r_echo_s    <= 1'b0;
         r_echo_d    <= 1'b0;
      end else begin
         r_echo_meta <= i_echo;
         r_echo_s    <= r_echo_meta;
         r_echo_d    <= r_echo_s;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state       <= S_IDLE;
         r_cnt         <= 24'd0;
         o_trigger     <= 1'b0;
         o_busy        <= 1'b0;
         o_echo_cycles <= 24'd0;
         o_valid       <= 1'b0;
         o_timeout     <= 1'b0;
      end else begin
         o_valid   <= 1'b0;
         o_timeout <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (i_start || C_AUTO) begin
                  r_state   <= S_TRIG;
                  r_cnt     <= 24'd0;
                  o_trigger <= 1'b1;
                  o_busy    <= 1'b1;
               end
            end
            S_TRIG: begin
               if (r_cnt >= C_TRIG_LAST) begin
                  r_state   <= S_WAIT_RISE;
                  r_cnt     <= 24'd0;
                  o_trigger <= 1'b0;
               end else begin
                  r_cnt <= w_cnt_inc;
               end
            end
            S_WAIT_RISE: begin
               if (w_rise) begin
                  r_state <= S_MEASURE;
                  r_cnt   <= 24'd0;
               end else if (r_cnt >= C_RISE_LAST) begin
                  r_state   <= S_HOLDOFF;
                  r_cnt     <= 24'd0;
                  o_timeout <= 1'b1;
               end else begin
                  r_cnt <= w_cnt_inc;
               end
            end
            S_MEASURE: begin
               // r_cnt holds high samples beyond the one seen on the rise clock.
               if (w_fall) begin
                  r_state       <= S_HOLDOFF;
                  r_cnt         <= 24'd0;
                  o_echo_cycles <= w_meas_total;
                  o_valid       <= 1'b1;
               end else if (r_cnt >= C_MEAS_LAST) begin
                  r_state   <= S_HOLDOFF;
                  r_cnt     <= 24'd0;
                  o_timeout <= 1'b1;
               end else if (r_echo_s) begin
                  r_cnt <= w_cnt_inc;
               end
            end
            S_HOLDOFF: begin
               if (r_cnt >= C_HOLD_LAST) begin
                  r_cnt <= 24'd0;
                  if (C_AUTO) begin
                     r_state   <= S_TRIG;
                     o_trigger <= 1'b1;
                  end else begin
                     r_state <= S_IDLE;
                     o_busy  <= 1'b0;
                  end
               end else begin
                  r_cnt <= w_cnt_inc;
               end
            end
            default: begin
               r_state   <= S_IDLE;
               r_cnt     <= 24'd0;
               o_trigger <= 1'b0;
               o_busy    <= 1'b0;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_urm_trigger.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_urm_trigger                                                |
// | Brief    : Self-checking bench for urm_trigger with a ranging model.     |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module tb_urm_trigger;

   localparam int TRIG = 5;
   localparam int TO   = 100;
   localparam int HO   = 20;

   logic        clk   = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic        echo  = 1'b0;
   logic        trigger;
   logic        busy;
   logic [23:0] echo_cycles;
   logic        valid;
   logic        timeout;

   int n_checks = 0;
   int n_fail   = 0;
   int exp_cyc  = 0;

   urm_trigger #(
      .TRIG_CYCLES        (TRIG),
      .ECHO_TIMEOUT_CYCLES(TO),
      .HOLDOFF_CYCLES     (HO)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .i_start      (start),
      .i_echo       (echo),
      .o_trigger    (trigger),
      .o_busy       (busy),
      .o_echo_cycles(echo_cycles),
      .o_valid      (valid),
      .o_timeout    (timeout)
   );

   always #5 clk = ~clk;

   // One start pulse; echo rises d clocks after trigger falls and lasts n clocks.
   task automatic run_meas(input int d, input int n, input bit stuck,
                           output int trig_w, output int n_valid, output int n_to,
                           output int n_both, output int fall_to_ev, output int ev_to_idle,
                           output bit hung);
      int  fall_k;
      int  ev_k;
      bit  prev_trig;
      trig_w = 0; n_valid = 0; n_to = 0; n_both = 0;
      fall_to_ev = -1; ev_to_idle = -1; hung = 1'b1;
      fall_k = -1; ev_k = -1; prev_trig = 1'b0;
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      for (int k = 0; k < 1000; k++) begin
         if (trigger) trig_w++;
         if (prev_trig && !trigger && fall_k < 0) fall_k = k;
         prev_trig = trigger;
         if (valid && timeout) n_both++;
         if (valid) n_valid++;
         if (timeout) n_to++;
         if ((valid || timeout) && ev_k < 0) ev_k = k;
         if (ev_k >= 0 && !busy) begin
            ev_to_idle = k - ev_k;
            hung = 1'b0;
            break;
         end
         if (fall_k >= 0)
            echo = stuck || (n > 0 && (k - fall_k) >= d && (k - fall_k) < d + n);
         else
            echo = stuck;
         @(negedge clk);
      end
      if (ev_k >= 0 && fall_k >= 0) fall_to_ev = ev_k - fall_k;
      echo = 1'b0;
      repeat (4) @(negedge clk);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      n_checks++;
      if ({trigger, busy, valid, timeout, echo_cycles} !== 28'd0) begin
         n_fail++;
         $display("FAIL reset_outputs: got trig=%b busy=%b valid=%b to=%b cyc=%0d required all 0",
                  trigger, busy, valid, timeout, echo_cycles);
      end
      rst_n = 1'b1;
      repeat (5) @(negedge clk);
      n_checks++;
      if (busy !== 1'b0 || trigger !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_idle: got busy=%b trig=%b required 0 0", busy, trigger);
      end
   endtask

   // Reference: echo widths below the timeout are measured exactly, otherwise abandoned.
   task automatic check_meas(input string name, input int d, input int n, input bit stuck);
      int tw, nv, nt, nb, fe, ei;
      bit hung;
      bit exp_valid;
      exp_valid = !stuck && n > 0 && n < TO;
      run_meas(d, n, stuck, tw, nv, nt, nb, fe, ei, hung);
      if (exp_valid) exp_cyc = n;
      n_checks++;
      if (hung) begin
         n_fail++;
         $display("FAIL %s_finish: no completion within cycle budget", name);
      end
      n_checks++;
      if (tw !== TRIG) begin
         n_fail++;
         $display("FAIL %s_trig_width: got %0d required %0d", name, tw, TRIG);
      end
      n_checks++;
      if (nv !== int'(exp_valid) || nt !== int'(!exp_valid)) begin
         n_fail++;
         $display("FAIL %s_outcome: got valid=%0d timeout=%0d required valid=%0d timeout=%0d",
                  name, nv, nt, exp_valid, !exp_valid);
      end
      n_checks++;
      if (nb !== 0) begin
         n_fail++;
         $display("FAIL %s_both: valid and timeout together %0d times required 0", name, nb);
      end
      n_checks++;
      if (echo_cycles !== 24'(exp_cyc)) begin
         n_fail++;
         $display("FAIL %s_cycles: got %0d required %0d", name, echo_cycles, exp_cyc);
      end
      n_checks++;
      if (ei !== HO) begin
         n_fail++;
         $display("FAIL %s_holdoff: got %0d required %0d", name, ei, HO);
      end
      if (stuck || n == 0) begin
         n_checks++;
         if (fe !== TO) begin
            n_fail++;
            $display("FAIL %s_rise_timeout: got %0d required %0d", name, fe, TO);
         end
      end
   endtask

   task automatic test_basic();
      check_meas("basic37", 10, 37, 1'b0);
   endtask

   task automatic test_no_echo();
      check_meas("no_echo", 0, 0, 1'b0);
   endtask

   task automatic test_stuck_high();
      echo = 1'b1;
      repeat (6) @(negedge clk);
      check_meas("stuck_high", 0, 0, 1'b1);
   endtask

   task automatic test_long_echo();
      check_meas("echo150", 5, 150, 1'b0);
      check_meas("echo99", 3, 99, 1'b0);
      check_meas("echo100", 3, 100, 1'b0);
      check_meas("echo1", 20, 1, 1'b0);
   endtask

   task automatic test_random();
      for (int i = 0; i < 8; i++) begin
         int d, n, sel;
         d   = $urandom_range(60, 0);
         sel = $urandom_range(3, 0);
         n   = (sel == 0) ? 0 : $urandom_range(130, 1);
         check_meas("random", d, n, 1'b0);
      end
   endtask

   task automatic test_start_held();
      int  rises;
      bit  prev_trig;
      bit  seen_busy;
      bit  idle_seen;
      rises = 0; prev_trig = 1'b0; seen_busy = 1'b0; idle_seen = 1'b0;
      @(negedge clk); start = 1'b1;
      @(negedge clk);
      for (int k = 0; k < 400; k++) begin
         if (trigger && !prev_trig) rises++;
         prev_trig = trigger;
         if (busy) seen_busy = 1'b1;
         if (seen_busy && !busy) begin
            idle_seen = 1'b1;
            break;
         end
         @(negedge clk);
      end
      n_checks++;
      if (!idle_seen || rises !== 1) begin
         n_fail++;
         $display("FAIL start_held_ignored: got idle=%0d trigger_rises=%0d required 1 1",
                  idle_seen, rises);
      end
      @(negedge clk);
      n_checks++;
      if (trigger !== 1'b1) begin
         n_fail++;
         $display("FAIL start_held_retrigger: got trigger=%b required 1", trigger);
      end
      start = 1'b0;
      for (int k = 0; k < 400; k++) begin
         if (!busy) break;
         @(negedge clk);
      end
      n_checks++;
      if (busy !== 1'b0) begin
         n_fail++;
         $display("FAIL start_held_finish: got busy=%b required 0", busy);
      end
      repeat (3) @(negedge clk);
   endtask

   task automatic test_reset_mid();
      int  stray;
      bit  fell;
      fell = 1'b0; stray = 0;
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      for (int k = 0; k < 50; k++) begin
         @(negedge clk);
         if (!trigger) begin
            fell = 1'b1;
            break;
         end
      end
      echo = 1'b1;
      repeat (20) @(negedge clk);
      n_checks++;
      if (!fell || busy !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_mid_setup: got fell=%0d busy=%b required 1 1", fell, busy);
      end
      rst_n = 1'b0;
      #1;
      n_checks++;
      if ({trigger, busy, valid, timeout, echo_cycles} !== 28'd0) begin
         n_fail++;
         $display("FAIL reset_mid_outputs: got trig=%b busy=%b valid=%b to=%b cyc=%0d required all 0",
                  trigger, busy, valid, timeout, echo_cycles);
      end
      repeat (3) @(negedge clk);
      echo = 1'b0;
      rst_n = 1'b1;
      for (int k = 0; k < 150; k++) begin
         @(negedge clk);
         if (valid || timeout || busy || trigger) stray++;
      end
      n_checks++;
      if (stray !== 0) begin
         n_fail++;
         $display("FAIL reset_mid_quiet: got %0d active clocks after release required 0", stray);
      end
      exp_cyc = 0;
   endtask

`ifdef URM_TRIGGER_AUTO_EN
   task automatic test_auto();
      int rise_k[$];
      int nv;
      int bad;
      bit prev_trig;
      int fall_k;
      nv = 0; bad = 0; prev_trig = 1'b0; fall_k = -1;
      for (int k = 0; k < 400; k++) begin
         @(negedge clk);
         if (trigger && !prev_trig) rise_k.push_back(k);
         if (!trigger && prev_trig) fall_k = k;
         prev_trig = trigger;
         if (valid) begin
            nv++;
            if (echo_cycles !== 24'd37) bad++;
         end
         echo = (fall_k >= 0 && (k - fall_k) >= 10 && (k - fall_k) < 47);
      end
      n_checks++;
      if (nv < 3 || bad !== 0) begin
         n_fail++;
         $display("FAIL auto_valid: got %0d pulses, %0d wrong values required >=3, 0", nv, bad);
      end
      for (int i = 1; i < rise_k.size(); i++) begin
         n_checks++;
         if (rise_k[i] - rise_k[i-1] !== TRIG + 10 + 3 + 37 + HO) begin
            n_fail++;
            $display("FAIL auto_period: got %0d required %0d",
                     rise_k[i] - rise_k[i-1], TRIG + 10 + 3 + 37 + HO);
         end
      end
   endtask
`endif

   initial begin
      test_reset();
`ifdef URM_TRIGGER_AUTO_EN
      test_auto();
`else
      test_basic();
      test_no_echo();
      test_stuck_high();
      test_long_echo();
      test_random();
      test_start_held();
      test_reset_mid();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
